// File: rtl/writeback_unit.sv
// Write-back arbiter: merges ALU and buffered LSU results onto one registered register-file write port.
// Optional WB_FWD_EN macro adds the decode forwarding compare ports (fwd_reg1/2, fwd_hit1/2).
module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     busy,
`ifdef WB_FWD_EN
  input  logic [4:0]      fwd_reg1,
  input  logic [4:0]      fwd_reg2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
`endif
  output logic            RegWr,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {ALU_PRI, FORCE_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            fifo_empty, fifo_full;
  logic            store, pop, alu_req, sel_alu;
  logic            wr_lsu_p1;
  logic [31:0]     busy_set, busy_clr;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign lsu_ready  = !fifo_full;
  // x0 pushes complete the handshake but never occupy an entry
  assign store      = lsu_valid && !fifo_full && (lsu_rd != 5'd0);
  assign alu_req    = alu_valid && (alu_rd != 5'd0);
  assign alu_stall  = (state == FORCE_DRAIN);

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    pop        = 1'b0;
    sel_alu    = 1'b0;
    case (state)
      ALU_PRI: begin
        if (alu_req) begin
          sel_alu = 1'b1;
          if (fifo_empty) begin
            starve_nxt = '0;
          end else begin
            starve_nxt = starve_cnt + 1'b1;
            if (starve_nxt == SW'(STARVE_MAX)) state_nxt = FORCE_DRAIN;
          end
        end else begin
          pop        = !fifo_empty;
          starve_nxt = '0;
        end
      end
      FORCE_DRAIN: begin
        pop        = !fifo_empty;
        starve_nxt = '0;
        state_nxt  = ALU_PRI;
      end
      default: state_nxt = ALU_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ALU_PRI;
      starve_cnt <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (store) tail <= (tail == PW'(FIFO_DEPTH - 1)) ? '0 : tail + 1'b1;
      if (pop)   head <= (head == PW'(FIFO_DEPTH - 1)) ? '0 : head + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      fifo_rd[tail]   <= lsu_rd;
      fifo_data[tail] <= lsu_data;
    end
  end

  // ---- write port stage (p1) ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      RegWr      <= 1'b0;
      wr_lsu_p1  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      RegWr     <= sel_alu || pop;
      wr_lsu_p1 <= pop;
      if (sel_alu) begin
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (pop) begin
        write_reg  <= fifo_rd[head];
        write_data <= fifo_data[head];
      end
    end
  end

  // Clear follows the visible LSU write; a same-cycle issue to that register re-sets it
  assign busy_clr = (RegWr && wr_lsu_p1) ? (32'd1 << write_reg) : 32'd0;
  assign busy_set = (issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) busy <= '0;
    else        busy <= ((busy & ~busy_clr) | busy_set) & ~32'd1;
  end

`ifdef WB_FWD_EN
  assign fwd_hit1 = RegWr && (write_reg != 5'd0) && (write_reg == fwd_reg1);
  assign fwd_hit2 = RegWr && (write_reg != 5'd0) && (write_reg == fwd_reg2);
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, LSU path with scoreboard, FIFO full/starvation, x0, reset.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_stall, lsu_ready, RegWr;
  logic [31:0] busy, write_data;
  logic [4:0]  write_reg;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_reg1, fwd_reg2;
  logic        fwd_hit1, fwd_hit2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
`ifdef WB_FWD_EN
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
`endif
    .RegWr(RegWr), .write_reg(write_reg), .write_data(write_data)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  initial begin
    n_rst = 0;
    idle();
`ifdef WB_FWD_EN
    fwd_reg1 = 0; fwd_reg2 = 0;
`endif
    tick(); tick();
    check("rst_regwr", RegWr, 0);
    check("rst_wreg", write_reg, 0);
    check("rst_wdata", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", lsu_ready, 1);
    check("rst_stall", alu_stall, 0);
    n_rst = 1;
    tick();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
    tick();
    idle();
    check("alu_regwr", RegWr, 1);
    check("alu_wreg", write_reg, 5);
    check("alu_wdata", write_data, 32'hDEAD_BEEF);
    tick();
    check("alu_idle", RegWr, 0);

    // LSU with scoreboard
    issue_valid = 1; issue_rd = 7;
    tick();
    idle();
    check("sb_set7", busy, 32'h80);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    tick();
    idle();
    check("lsu_push_nowr", RegWr, 0);
    tick();
    check("lsu_regwr", RegWr, 1);
    check("lsu_wreg", write_reg, 7);
    check("lsu_wdata", write_data, 32'h1234);
    check("lsu_busy_held", busy, 32'h80);
    tick();
    check("lsu_busy_clr", busy, 0);
    check("lsu_idle", RegWr, 0);

    // set/clear collision on r3
    issue_valid = 1; issue_rd = 3;
    tick();
    idle();
    check("col_set3", busy, 32'h8);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
    tick();
    idle();
    tick();
    check("col_wreg", write_reg, 3);
    issue_valid = 1; issue_rd = 3;
    tick();
    idle();
    check("col_setwins", busy, 32'h8);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h34;
    tick();
    idle();
    tick();
    tick();
    check("col_cleared", busy, 0);

    // FIFO full and forced drain
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA;
    tick();
    check("full_ready1", lsu_ready, 1);
    check("full_alu1", write_reg, 1);
    lsu_rd = 11; lsu_data = 32'hB;
    tick();
    check("full_ready0", lsu_ready, 0);
    check("full_stall_e2", alu_stall, 0);
    lsu_rd = 12; lsu_data = 32'hC;
    tick();
    lsu_valid = 0;
    check("full_refused", lsu_ready, 0);
    check("full_stall_e3", alu_stall, 0);
    tick();
    check("full_stall_e4", alu_stall, 0);
    tick();
    check("drain_stall", alu_stall, 1);
    check("drain_alu4", write_reg, 1);
    tick();
    alu_valid = 0;
    check("drain_regwr", RegWr, 1);
    check("drain_wreg", write_reg, 10);
    check("drain_wdata", write_data, 32'hA);
    check("drain_unstall", alu_stall, 0);
    check("drain_ready", lsu_ready, 1);
    tick();
    check("pop2_wreg", write_reg, 11);
    check("pop2_wdata", write_data, 32'hB);
    tick();
    check("fifo_empty", RegWr, 0);

    // x0 handling
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h66;
    issue_valid = 1; issue_rd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("x0_regwr", RegWr, 0);
      check("x0_busy", busy, 0);
      check("x0_ready", lsu_ready, 1);
    end
    idle();
    tick();
    check("x0_after", RegWr, 0);

`ifdef WB_FWD_EN
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    fwd_reg1 = 9; fwd_reg2 = 0;
    tick();
    idle();
    check("fwd_hit1", fwd_hit1, 1);
    check("fwd_hit2", fwd_hit2, 0);
    tick();
    check("fwd_idle", fwd_hit1, 0);
`endif

    // reset mid-operation
    issue_valid = 1; issue_rd = 3;
    tick();
    issue_rd = 7;
    tick();
    idle();
    check("mid_busy", busy, 32'h88);
    alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h20;
    tick();
    lsu_rd = 21; lsu_data = 32'h21;
    tick();
    check("mid_full", lsu_ready, 0);
    #2;
    n_rst = 0;
    #1;
    check("mid_rst_regwr", RegWr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wreg", write_reg, 0);
    check("mid_rst_wdata", write_data, 0);
    check("mid_rst_ready", lsu_ready, 1);
    check("mid_rst_stall", alu_stall, 0);
    idle();
    tick();
    n_rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_regwr", RegWr, 0);
      check("post_rst_ready", lsu_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
